// File: rtl/float_div_iter.sv
// float_div_iter: iterative floating-point divider.
// Radix-2 restoring division of the hidden-bit mantissas, one quotient bit
// per enabled clock, followed by a single normalise/round step. Special
// operands (zero, inf, NaN) bypass the iteration and complete at the accept
// edge. Denormal inputs are flushed to zero and results never produce
// denormals (they underflow to signed zero).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE while enable is high; out_valid stays high
// with stable results in DONE until out_ready is seen on an enabled edge.
module float_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] a_man,
  input  logic [EXP_W-1:0] a_exp,
  input  logic             a_sign,
  input  logic [MAN_W-1:0] b_man,
  input  logic [EXP_W-1:0] b_exp,
  input  logic             b_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] r_man,
  output logic [EXP_W-1:0] r_exp,
  output logic             r_sign,
  output logic [3:0]       flags
);

  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int Q     = MAN_W + 3;
  localparam int CNT_W = $clog2(Q + 1);
  localparam int XW    = EXP_W + 2;

  // Exponent arithmetic runs at XW bits so negative and overflowing values
  // are representable as two's complement.
  localparam logic [XW-1:0] BIAS_X    = XW'(BIAS);
  localparam logic [XW-1:0] EXP_TOP_X = XW'((1 << EXP_W) - 1);
  localparam logic [XW-1:0] ONE_X     = XW'(1);

  localparam logic [MAN_W-1:0] QNAN_MAN = {1'b1, {(MAN_W - 1){1'b0}}};
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  // Flag bit order: {invalid, div_by_zero, overflow, underflow}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_INV  = 4'b1000;
  localparam logic [3:0] F_DBZ  = 4'b0100;
  localparam logic [3:0] F_OVF  = 4'b0010;
  localparam logic [3:0] F_UNF  = 4'b0001;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Operation registers captured at accept.
  logic             sign_r;
  logic [XW-1:0]    exp_r;
  logic [MAN_W+1:0] rem_r;
  logic [MAN_W:0]   div_r;
  logic [Q-1:0]     quo_r;

  // Operand classification.
  logic a_is_zero, a_is_inf, a_is_nan;
  logic b_is_zero, b_is_inf, b_is_nan;

  // Special-case result.
  logic             spec_hit;
  logic             spec_sign;
  logic [EXP_W-1:0] spec_exp;
  logic [MAN_W-1:0] spec_man;
  logic [3:0]       spec_flags;

  // Division step.
  logic             rem_ge;
  logic [MAN_W+1:0] rem_diff;
  logic [MAN_W+1:0] rem_step;

  // Normalise / round.
  logic [Q-2:0]     norm_low;
  logic [XW-1:0]    exp_n;
  logic             guard_bit;
  logic             sticky_bit;
  logic             lsb_bit;
  logic             round_up;
  logic             man_carry;
  logic [MAN_W-1:0] man_rnd;
  logic [XW-1:0]    exp_f;
  logic             exp_ovf;
  logic             exp_unf;

  logic [XW-1:0]    exp_start;

  assign in_ready = (state == S_IDLE) && enable;

  assign exp_start = {2'b00, a_exp} - {2'b00, b_exp} + BIAS_X;

  // Classify operands: exponent 0 is zero (denormals flushed), all-ones is inf/NaN.
  always_comb begin
    a_is_zero = (a_exp == '0);
    a_is_inf  = (a_exp == EXP_ONES) && (a_man == '0);
    a_is_nan  = (a_exp == EXP_ONES) && (a_man != '0);
    b_is_zero = (b_exp == '0);
    b_is_inf  = (b_exp == EXP_ONES) && (b_man == '0);
    b_is_nan  = (b_exp == EXP_ONES) && (b_man != '0);
  end

  // Special-case result table; priority order resolves NaN before everything.
  always_comb begin
    spec_hit   = 1'b0;
    spec_sign  = a_sign ^ b_sign;
    spec_exp   = '0;
    spec_man   = '0;
    spec_flags = F_NONE;
    if (a_is_nan || b_is_nan || (a_is_zero && b_is_zero) || (a_is_inf && b_is_inf)) begin
      spec_hit   = 1'b1;
      spec_sign  = 1'b0;
      spec_exp   = EXP_ONES;
      spec_man   = QNAN_MAN;
      spec_flags = F_INV;
    end else if (a_is_inf) begin
      // inf divided by anything finite (zero included) stays inf, no exception
      spec_hit = 1'b1;
      spec_exp = EXP_ONES;
    end else if (b_is_zero) begin
      spec_hit   = 1'b1;
      spec_exp   = EXP_ONES;
      spec_flags = F_DBZ;
    end else if (a_is_zero || b_is_inf) begin
      spec_hit = 1'b1;
    end
  end

  // One restoring-division step: subtract divisor if it fits, then shift.
  always_comb begin
    rem_ge   = (rem_r >= {1'b0, div_r});
    rem_diff = rem_r - {1'b0, div_r};
    rem_step = rem_ge ? {rem_diff[MAN_W:0], 1'b0} : {rem_r[MAN_W:0], 1'b0};
  end

  // Normalise the quotient below the hidden bit and round to nearest even.
  // Below the stored mantissa there is one guard bit and one more bit that
  // joins the remainder in the sticky term.
  always_comb begin
    if (quo_r[Q-1]) begin
      norm_low = quo_r[Q-2:0];
      exp_n    = exp_r;
    end else begin
      norm_low = {quo_r[Q-3:0], 1'b0};
      exp_n    = exp_r - ONE_X;
    end
    guard_bit  = norm_low[1];
    sticky_bit = norm_low[0] | (|rem_r);
    lsb_bit    = norm_low[2];
    round_up   = guard_bit & (sticky_bit | lsb_bit);
    {man_carry, man_rnd} = {1'b0, norm_low[Q-2:2]} + {{MAN_W{1'b0}}, round_up};
    exp_f   = exp_n + {{(XW - 1){1'b0}}, man_carry};
    exp_ovf = ($signed(exp_f) >= $signed(EXP_TOP_X));
    exp_unf = exp_f[XW-1] || (exp_f == '0);
  end

  // Control FSM and datapath registers; nothing moves while enable is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      rem_r     <= '0;
      div_r     <= '0;
      quo_r     <= '0;
      out_valid <= 1'b0;
      r_man     <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      flags     <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_r <= a_sign ^ b_sign;
            exp_r  <= exp_start;
            rem_r  <= {1'b0, 1'b1, a_man};
            div_r  <= {1'b1, b_man};
            quo_r  <= '0;
            cnt    <= '0;
            if (spec_hit) begin
              r_sign    <= spec_sign;
              r_exp     <= spec_exp;
              r_man     <= spec_man;
              flags     <= spec_flags;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo_r <= {quo_r[Q-2:0], rem_ge};
          rem_r <= rem_step;
          if (cnt == CNT_W'(Q - 1)) begin
            cnt   <= '0;
            state <= S_ROUND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ROUND: begin
          r_sign <= sign_r;
          if (exp_ovf) begin
            r_exp <= EXP_ONES;
            r_man <= '0;
            flags <= F_OVF;
          end else if (exp_unf) begin
            r_exp <= '0;
            r_man <= '0;
            flags <= F_UNF;
          end else begin
            r_exp <= exp_f[EXP_W-1:0];
            r_man <= man_rnd;
            flags <= F_NONE;
          end
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_div_iter.sv
// tb_float_div_iter: directed vector table, hand-written stall/backpressure
// and reset sequences, and random operands checked against an exact-division
// reference model.
module tb_float_div_iter;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] a_man;
  logic [7:0]  a_exp;
  logic        a_sign;
  logic [22:0] b_man;
  logic [7:0]  b_exp;
  logic        b_sign;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] r_man;
  logic [7:0]  r_exp;
  logic        r_sign;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  // Packed result: {sign, exp[7:0], man[22:0], flags[3:0]}
  logic [35:0] exp_q[$];

  typedef struct {
    logic        a_s;
    logic [7:0]  a_e;
    logic [22:0] a_m;
    logic        b_s;
    logic [7:0]  b_e;
    logic [22:0] b_m;
    logic [35:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  float_div_iter dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_man(a_man), .a_exp(a_exp), .a_sign(a_sign),
    .b_man(b_man), .b_exp(b_exp), .b_sign(b_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_man(r_man), .r_exp(r_exp), .r_sign(r_sign), .flags(flags)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] pack(input logic s, input logic [7:0] e,
                                       input logic [22:0] m, input logic [3:0] f);
    return {s, e, m, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic bit is_special(input logic [7:0] ae, input logic [7:0] be);
    return (ae == 8'd0) || (ae == 8'd255) || (be == 8'd0) || (be == 8'd255);
  endfunction

  // Reference model: exact integer quotient, then round-to-nearest-even on
  // the true remainder.
  function automatic logic [35:0] model(input logic as, input logic [7:0] ae, input logic [22:0] am,
                                        input logic bs, input logic [7:0] be, input logic [22:0] bm);
    logic s;
    bit a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    longint ma, mb, num, m, r;
    int e;
    s = as ^ bs;
    a_zero = (ae == 0);
    a_inf  = (ae == 255) && (am == 0);
    a_nan  = (ae == 255) && (am != 0);
    b_zero = (be == 0);
    b_inf  = (be == 255) && (bm == 0);
    b_nan  = (be == 255) && (bm != 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      return pack(1'b0, 8'd255, 23'h400000, 4'b1000);
    if (a_inf) return pack(s, 8'd255, 23'h0, 4'b0000);
    if (b_zero) return pack(s, 8'd255, 23'h0, 4'b0100);
    if (a_zero || b_inf) return pack(s, 8'd0, 23'h0, 4'b0000);
    ma = longint'(am) + (longint'(1) << 23);
    mb = longint'(bm) + (longint'(1) << 23);
    e  = int'(ae) - int'(be) + 127;
    if (ma >= mb) num = ma << 23;
    else begin
      num = ma << 24;
      e   = e - 1;
    end
    m = num / mb;
    r = num % mb;
    if ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1))) m = m + 1;
    if (m == (longint'(1) << 24)) begin
      m = longint'(1) << 23;
      e = e + 1;
    end
    if (e >= 255) return pack(s, 8'd255, 23'h0, 4'b0010);
    if (e <= 0) return pack(s, 8'd0, 23'h0, 4'b0001);
    return pack(s, 8'(e), 23'(m), 4'b0000);
  endfunction

  // Driver: present one operation, optionally drop enable for stall_len
  // cycles starting stall_at edges after accept, optionally hold out_ready
  // low for hold cycles once the result is up. lat counts edges after the
  // accept edge until out_valid is seen.
  task automatic do_op(input logic as, input logic [7:0] ae, input logic [22:0] am,
                       input logic bs, input logic [7:0] be, input logic [22:0] bm,
                       input int stall_at, input int stall_len, input int hold,
                       output logic [35:0] got, output int lat);
    int tries;
    @(negedge clk);
    a_sign = as; a_exp = ae; a_man = am;
    b_sign = bs; b_exp = be; b_man = bm;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    if (!out_valid) check("busy_in_ready", 64'(in_ready), 64'd0);
    while (!out_valid && lat < 200) begin
      if (stall_len > 0 && lat == stall_at) enable = 1'b0;
      if (lat == stall_at + stall_len) enable = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    enable = 1'b1;
    if (!out_valid) check("result_timeout", 64'(out_valid), 64'd1);
    got = {r_sign, r_exp, r_man, flags};
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_stable", 64'({r_sign, r_exp, r_man, flags}), 64'(got));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("consumed_valid", 64'(out_valid), 64'd0);
  endtask

  logic [35:0] got;
  logic [35:0] want;
  int          lat;
  int          cyc;
  bit          seen;

  initial begin
    rstn = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_man = '0; a_exp = '0; a_sign = 1'b0;
    b_man = '0; b_exp = '0; b_sign = 1'b0;

    // Reset state
    #3 rstn = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'({r_sign, r_exp, r_man, flags}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);
    enable = 1'b0;
    #1;
    check("disabled_in_ready", 64'(in_ready), 64'd0);
    enable = 1'b1;

    // Directed vectors: {a, b, expected result, expected latency}
    vecs.push_back('{1'b0, 8'd129, 23'h400000, 1'b0, 8'd128, 23'h0, pack(1'b0, 8'd128, 23'h400000, 4'b0000), 27});
    vecs.push_back('{1'b0, 8'd127, 23'h0, 1'b0, 8'd128, 23'h400000, pack(1'b0, 8'd125, 23'h2AAAAB, 4'b0000), 27});
    vecs.push_back('{1'b0, 8'd127, 23'h0, 1'b0, 8'd0, 23'h0, pack(1'b0, 8'd255, 23'h0, 4'b0100), 0});
    vecs.push_back('{1'b0, 8'd0, 23'h0, 1'b0, 8'd0, 23'h0, pack(1'b0, 8'd255, 23'h400000, 4'b1000), 0});
    vecs.push_back('{1'b0, 8'd254, 23'h0, 1'b0, 8'd1, 23'h0, pack(1'b0, 8'd255, 23'h0, 4'b0010), 27});
    vecs.push_back('{1'b0, 8'd1, 23'h0, 1'b0, 8'd254, 23'h0, pack(1'b0, 8'd0, 23'h0, 4'b0001), 27});
    vecs.push_back('{1'b1, 8'd129, 23'h400000, 1'b0, 8'd128, 23'h0, pack(1'b1, 8'd128, 23'h400000, 4'b0000), 27});
    vecs.push_back('{1'b0, 8'd255, 23'h0, 1'b1, 8'd128, 23'h0, pack(1'b1, 8'd255, 23'h0, 4'b0000), 0});
    vecs.push_back('{1'b1, 8'd128, 23'h0, 1'b0, 8'd255, 23'h0, pack(1'b1, 8'd0, 23'h0, 4'b0000), 0});
    vecs.push_back('{1'b1, 8'd255, 23'h1, 1'b0, 8'd127, 23'h0, pack(1'b0, 8'd255, 23'h400000, 4'b1000), 0});
    vecs.push_back('{1'b0, 8'd255, 23'h0, 1'b1, 8'd255, 23'h0, pack(1'b0, 8'd255, 23'h400000, 4'b1000), 0});
    vecs.push_back('{1'b1, 8'd127, 23'h0, 1'b1, 8'd0, 23'h5, pack(1'b0, 8'd255, 23'h0, 4'b0100), 0});
    vecs.push_back('{1'b0, 8'd127, 23'h400000, 1'b0, 8'd127, 23'h400000, pack(1'b0, 8'd127, 23'h0, 4'b0000), 27});
    vecs.push_back('{1'b0, 8'd127, 23'h0, 1'b0, 8'd127, 23'h7FFFFF, pack(1'b0, 8'd126, 23'h000001, 4'b0000), 27});
    vecs.push_back('{1'b0, 8'd1, 23'h0, 1'b0, 8'd128, 23'h0, pack(1'b0, 8'd0, 23'h0, 4'b0001), 27});
    vecs.push_back('{1'b0, 8'd254, 23'h0, 1'b0, 8'd127, 23'h0, pack(1'b0, 8'd254, 23'h0, 4'b0000), 27});
    vecs.push_back('{1'b1, 8'd254, 23'h400000, 1'b0, 8'd126, 23'h0, pack(1'b1, 8'd255, 23'h0, 4'b0010), 27});
    vecs.push_back('{1'b0, 8'd1, 23'h400000, 1'b0, 8'd127, 23'h0, pack(1'b0, 8'd1, 23'h400000, 4'b0000), 27});

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].res);
      do_op(vecs[i].a_s, vecs[i].a_e, vecs[i].a_m, vecs[i].b_s, vecs[i].b_e, vecs[i].b_m,
            0, 0, 0, got, lat);
      want = exp_q.pop_front();
      check($sformatf("vec%0d_result", i), 64'(got), 64'(want));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: result held for 5 cycles with out_ready low
    do_op(1'b0, 8'd129, 23'h400000, 1'b0, 8'd128, 23'h0, 0, 0, 5, got, lat);
    check("hold_result", 64'(got), 64'(pack(1'b0, 8'd128, 23'h400000, 4'b0000)));
    // Special result under backpressure
    do_op(1'b0, 8'd0, 23'h0, 1'b0, 8'd0, 23'h0, 0, 0, 3, got, lat);
    check("hold_special", 64'(got), 64'(pack(1'b0, 8'd255, 23'h400000, 4'b1000)));

    // Enable dropped for 3 cycles mid-CALC adds exactly 3 to the latency
    do_op(1'b0, 8'd127, 23'h0, 1'b0, 8'd128, 23'h400000, 5, 3, 0, got, lat);
    check("stall_result", 64'(got), 64'(pack(1'b0, 8'd125, 23'h2AAAAB, 4'b0000)));
    check("stall_latency", 64'(lat), 64'd30);

    // Reset pulsed at CALC cycle 10 discards the operation
    @(negedge clk);
    a_sign = 1'b0; a_exp = 8'd129; a_man = 23'h400000;
    b_sign = 1'b0; b_exp = 8'd128; b_man = 23'h0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("calc_rst_valid", 64'(out_valid), 64'd0);
    check("calc_rst_result", 64'({r_sign, r_exp, r_man, flags}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("calc_rst_no_output", 64'(seen), 64'd0);
    do_op(1'b0, 8'd127, 23'h0, 1'b0, 8'd128, 23'h400000, 0, 0, 0, got, lat);
    check("after_rst_result", 64'(got), 64'(pack(1'b0, 8'd125, 23'h2AAAAB, 4'b0000)));
    check("after_rst_latency", 64'(lat), 64'd27);

    // Randomized operands against the reference model
    for (int n = 0; n < 80; n++) begin
      logic        as, bs;
      logic [7:0]  ae, be;
      logic [22:0] am, bm;
      int          kind, hold, st_at, st_len, exp_lat;
      kind = $urandom_range(0, 9);
      as = 1'($urandom_range(0, 1));
      bs = 1'($urandom_range(0, 1));
      am = 23'($urandom());
      bm = 23'($urandom());
      if (kind < 6) begin
        ae = 8'($urandom_range(100, 154));
        be = 8'($urandom_range(100, 154));
      end else if (kind < 8) begin
        ae = 8'($urandom_range(1, 254));
        be = 8'($urandom_range(1, 254));
      end else if (kind == 8) begin
        ae = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'd255;
        be = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 254));
        if ($urandom_range(0, 1) == 1) am = 23'h0;
        if ($urandom_range(0, 1) == 1) begin
          logic [7:0] t;
          t = ae; ae = be; be = t;
        end
      end else begin
        ae = 8'($urandom_range(120, 134));
        be = 8'($urandom_range(120, 134));
        am = ($urandom_range(0, 1) == 1) ? 23'h7FFFFF : 23'($urandom_range(0, 3));
        bm = ($urandom_range(0, 1) == 1) ? 23'h7FFFFF : 23'($urandom_range(0, 3));
      end
      hold   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      st_at  = $urandom_range(0, 20);
      st_len = $urandom_range(0, 2);
      exp_lat = is_special(ae, be) ? 0 : 27 + st_len;
      exp_q.push_back(model(as, ae, am, bs, be, bm));
      do_op(as, ae, am, bs, be, bm, st_at, st_len, hold, got, lat);
      want = exp_q.pop_front();
      check($sformatf("rand%0d_result", n), 64'(got), 64'(want));
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'(exp_lat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
